// File: rtl/fpu_sp_result_stage.sv
// Result stage behind the single-precision multiplier: turns raw products
// into IEEE-correct results (inf / signed zero / quiet NaN), queues them in
// a show-ahead FIFO, and keeps sticky exception flags and a saturating count
// of exceptional results.
module fpu_sp_result_stage #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_overflow,
  input  logic                     in_underflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [2:0]               out_flags,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     flag_clr,
  output logic [2:0]               sticky_flags,
  output logic [7:0]               exc_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem_data  [DEPTH];
  logic [2:0]       r_mem_flags [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             r_rdy_en;
  logic [2:0]       r_sticky;
  logic [7:0]       r_exc;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_exc;
  logic             w_sign;
  logic [WIDTH-1:0] w_corr_data;
  logic [2:0]       w_corr_flags;

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign in_ready  = r_rdy_en & ~w_full;
  assign out_valid = ~w_empty;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_exc     = w_push & (w_corr_flags != 3'b000);
  assign w_sign    = in_result[31];

  // Head is read straight from the storage registers; gating with out_valid
  // keeps out_data/out_flags at zero while empty, including during reset.
  assign out_data     = out_valid ? r_mem_data[r_rptr]  : '0;
  assign out_flags    = out_valid ? r_mem_flags[r_rptr] : '0;
  assign level        = r_level;
  assign sticky_flags = r_sticky;
  assign exc_count    = r_exc;

  // Product correction: overflow beats underflow, which beats NaN quieting.
  always_comb begin
    w_corr_data  = in_result;
    w_corr_flags = 3'b000;
    if (in_overflow) begin
      w_corr_data  = {w_sign, 8'hFF, 23'h0};
      w_corr_flags = 3'b010;
    end else if (in_underflow) begin
      w_corr_data  = {w_sign, 31'h0};
      w_corr_flags = 3'b001;
    end else if ((in_result[30:23] == 8'hFF) && (in_result[22:0] != 23'h0)) begin
      w_corr_data  = 32'h7FC0_0000;
      w_corr_flags = 3'b100;
    end
  end

  // Entry storage; contents are only visible through a valid head, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr]  <= w_corr_data;
      r_mem_flags[r_wptr] <= w_corr_flags;
    end
  end

  // Pointers, occupancy and the post-reset ready enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky flags and saturating exception count; an accept in the clear cycle survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= '0;
      r_exc    <= '0;
    end else if (flag_clr) begin
      r_sticky <= w_push ? w_corr_flags : 3'b000;
      r_exc    <= w_exc ? 8'd1 : 8'd0;
    end else begin
      if (w_push) r_sticky <= r_sticky | w_corr_flags;
      if (w_exc && (r_exc != 8'hFF)) r_exc <= r_exc + 8'd1;
    end
  end

endmodule

// File: tb/tb_fpu_sp_result_stage.sv
// Directed bench for fpu_sp_result_stage with hand-computed expectations.
module tb_fpu_sp_result_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_overflow;
  logic        in_underflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_flags;
  logic [2:0]  level;
  logic        flag_clr;
  logic [2:0]  sticky_flags;
  logic [7:0]  exc_count;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_sp_result_stage #(.DEPTH(4), .WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_overflow  (in_overflow),
    .in_underflow (in_underflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_flags    (out_flags),
    .level        (level),
    .flag_clr     (flag_clr),
    .sticky_flags (sticky_flags),
    .exc_count    (exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] d, input logic ov, input logic un);
    in_valid     = v;
    in_result    = d;
    in_overflow  = ov;
    in_underflow = un;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] d, input logic [2:0] f);
    check_eq({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
    check_eq({tag, "_data"},  out_data, d);
    check_eq({tag, "_flags"}, {29'h0, out_flags}, {29'h0, f});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    flag_clr = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_level",  {29'h0, level}, 32'h0);
    check_eq("rst_ovalid", {31'h0, out_valid}, 32'h0);
    check_eq("rst_iready", {31'h0, in_ready}, 32'h0);
    check_eq("rst_sticky", {29'h0, sticky_flags}, 32'h0);
    check_eq("rst_exc",    {24'h0, exc_count}, 32'h0);
    check_eq("rst_odata",  out_data, 32'h0);
    check_eq("rst_oflags", {29'h0, out_flags}, 32'h0);
    #19 rst_n = 1'b1;
    #1;
    check_eq("prerdy_iready", {31'h0, in_ready}, 32'h0);
    tick();
    check_eq("postrst_iready", {31'h0, in_ready}, 32'h1);

    // Plain product passes through with latency 1.
    set_in(1'b1, 32'h41570A3D, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("plain_level", {29'h0, level}, 32'h1);
    check_eq("plain_exc", {24'h0, exc_count}, 32'h0);
    pop_expect("plain", 32'h41570A3D, 3'b000);
    check_eq("plain_drained", {29'h0, level}, 32'h0);

    // Overflow, underflow, both-set (overflow wins).
    set_in(1'b1, 32'h3F800000, 1'b1, 1'b0); tick();
    set_in(1'b1, 32'hC0000000, 1'b0, 1'b1); tick();
    set_in(1'b1, 32'h80001234, 1'b1, 1'b1); tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("ou_level", {29'h0, level}, 32'h3);
    check_eq("ou_sticky", {29'h0, sticky_flags}, 32'h3);
    check_eq("ou_exc", {24'h0, exc_count}, 32'h3);
    pop_expect("ovf", 32'h7F800000, 3'b010);
    pop_expect("unf", 32'h80000000, 3'b001);
    pop_expect("both", 32'hFF800000, 3'b010);

    // NaN quieting; infinity untouched.
    set_in(1'b1, 32'h7F812345, 1'b0, 1'b0); tick();
    set_in(1'b1, 32'h7F800000, 1'b0, 1'b0); tick();
    set_in(1'b1, 32'hFFC00001, 1'b0, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    pop_expect("nan", 32'h7FC00000, 3'b100);
    pop_expect("inf", 32'h7F800000, 3'b000);
    pop_expect("negnan", 32'h7FC00000, 3'b100);
    check_eq("nan_sticky", {29'h0, sticky_flags}, 32'h7);
    check_eq("nan_exc", {24'h0, exc_count}, 32'h5);

    // Clear coincident with overflow accept: the accept wins.
    flag_clr = 1'b1;
    set_in(1'b1, 32'h00000000, 1'b1, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    flag_clr = 1'b0;
    check_eq("clrw_sticky", {29'h0, sticky_flags}, 32'h2);
    check_eq("clrw_exc", {24'h0, exc_count}, 32'h1);
    flag_clr = 1'b1; tick(); flag_clr = 1'b0;
    check_eq("clr_sticky", {29'h0, sticky_flags}, 32'h0);
    check_eq("clr_exc", {24'h0, exc_count}, 32'h0);
    pop_expect("clrw", 32'h7F800000, 3'b010);

    // Fill to full, fifth push refused.
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 32'h40000000 + i, 1'b0, 1'b0);
      tick();
      if (i == 3) begin
        check_eq("full_level", {29'h0, level}, 32'h4);
        check_eq("full_iready", {31'h0, in_ready}, 32'h0);
      end
    end
    check_eq("held_level", {29'h0, level}, 32'h4);
    check_eq("held_head", out_data, 32'h40000000);
    // Full with pop: push still refused, ready returns after the pop.
    out_ready = 1'b1;
    set_in(1'b1, 32'h40000004, 1'b0, 1'b0);
    tick();
    check_eq("fullpop_level", {29'h0, level}, 32'h3);
    check_eq("fullpop_iready", {31'h0, in_ready}, 32'h1);
    check_eq("fullpop_head", out_data, 32'h40000001);
    // Simultaneous push and pop keeps level.
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    out_ready = 1'b0;
    check_eq("pushpop_level", {29'h0, level}, 32'h3);
    pop_expect("drain2", 32'h40000002, 3'b000);
    pop_expect("drain3", 32'h40000003, 3'b000);
    pop_expect("drain4", 32'h40000004, 3'b000);
    check_eq("drain_level", {29'h0, level}, 32'h0);
    check_eq("drain_exc", {24'h0, exc_count}, 32'h0);

    // Saturation of the exception counter.
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      set_in(1'b1, 32'h00000001, 1'b1, 1'b0);
      tick();
      if (i == 253) check_eq("sat_254", {24'h0, exc_count}, 32'd254);
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    out_ready = 1'b0;
    check_eq("sat_exc", {24'h0, exc_count}, 32'd255);
    check_eq("sat_sticky", {29'h0, sticky_flags}, 32'h2);
    check_eq("sat_level", {29'h0, level}, 32'h0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h3E000000 + i, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("mid_level", {29'h0, level}, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_level", {29'h0, level}, 32'h0);
    check_eq("arst_ovalid", {31'h0, out_valid}, 32'h0);
    check_eq("arst_iready", {31'h0, in_ready}, 32'h0);
    check_eq("arst_exc", {24'h0, exc_count}, 32'h0);
    check_eq("arst_odata", out_data, 32'h0);
    #3 rst_n = 1'b1;
    tick();
    check_eq("rel_iready", {31'h0, in_ready}, 32'h1);
    set_in(1'b1, 32'h3F000000, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("rel_level", {29'h0, level}, 32'h1);
    pop_expect("rel", 32'h3F000000, 3'b000);
    check_eq("rel_empty", {31'h0, out_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
